cmp_seq_32bits: RTL and testbench

- Multi-cycle 32-bit comparison unit for the CPU's SLT/SLTU/SLTI/SLTIU results and conditional-branch resolution.
- Feeds one 16-bit unsigned compare slice per cycle, low half first, then high half.
- Merges the two slice results into a 3-bit magnitude result, a branch condition and a 32-bit set-less-than value.
- Sits between the ID/EX operand latch and the writeback/PC-select logic. Start/busy/done handshake with the control FSM.

---
 rtl/cmp_seq_32bits.sv | 120 ++++++++++++
 tb/tb_cmp_seq_32bits.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq_32bits.sv
// Multi-cycle 32-bit magnitude comparator: one 16-bit unsigned slice per cycle,
// low half first, merged into {gt,eq,lt}, a branch condition and an SLT value.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// LO    | compare low 16-bit slice, keep lo_res
// HI    | compare high slice, merge, register result/cond/slt_out
// DONE  | done pulse for one cycle, back to IDLE
module cmp_seq_32bits #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result,
  output logic             cond,
  output logic [WIDTH-1:0] slt_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] RES_EQ = 3'b010;

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_GE = 3'b011;
  localparam logic [2:0] OP_GT = 3'b100;
  localparam logic [2:0] OP_LE = 3'b101;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [2:0]       op_q;
  logic [2:0]       lo_res;
  logic [2:0]       hi_res;
  logic [2:0]       final_res;
  logic [WIDTH-1:0] sign_mask;

  function automatic logic [2:0] cmp_slice(input logic [SLICE-1:0] x,
                                           input logic [SLICE-1:0] y);
    if (x > y)
      return 3'b100;
    else if (x == y)
      return 3'b010;
    else
      return 3'b001;
  endfunction

  function automatic logic cond_of(input logic [2:0] sel, input logic [2:0] res);
    logic gt, eq, lt;
    {gt, eq, lt} = res;
    case (sel)
      OP_EQ:   return eq;
      OP_NE:   return ~eq;
      OP_LT:   return lt;
      OP_GE:   return gt | eq;
      OP_GT:   return gt;
      OP_LE:   return lt | eq;
      default: return 1'b0;
    endcase
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_mask = {is_signed, {(WIDTH-1){1'b0}}};

  assign hi_res    = cmp_slice(ra[WIDTH-1:SLICE], rb[WIDTH-1:SLICE]);
  assign final_res = (hi_res != RES_EQ) ? hi_res : lo_res;

  assign busy = (state == ST_LO) || (state == ST_HI);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ra      <= '0;
      rb      <= '0;
      op_q    <= 3'b000;
      lo_res  <= RES_EQ;
      result  <= RES_EQ;
      cond    <= 1'b0;
      slt_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a ^ sign_mask;
            rb    <= b ^ sign_mask;
            op_q  <= op;
            state <= ST_LO;
          end
        end
        ST_LO: begin
          lo_res <= cmp_slice(ra[SLICE-1:0], rb[SLICE-1:0]);
          state  <= ST_HI;
        end
        ST_HI: begin
          result  <= final_res;
          cond    <= cond_of(op_q, final_res);
          slt_out <= {{(WIDTH-1){1'b0}}, final_res[0]};
          state   <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_32bits.sv
// Self-checking bench for cmp_seq_32bits: directed vectors, random compares
// against a plain-arithmetic reference, reset abort and held-start handshake.
module tb_cmp_seq_32bits;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [2:0]  result;
  logic        cond;
  logic [31:0] slt_out;

  int checks = 0;
  int errors = 0;

  cmp_seq_32bits dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cond      (cond),
    .slt_out   (slt_out)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end else begin
      if (x > y) return 3'b100;
      if (x < y) return 3'b001;
      return 3'b010;
    end
  endfunction

  function automatic logic ref_cond(input logic [2:0] o, input logic [2:0] r);
    case (o)
      3'd0:    return r == 3'b010;
      3'd1:    return r != 3'b010;
      3'd2:    return r == 3'b001;
      3'd3:    return r != 3'b001;
      3'd4:    return r == 3'b100;
      3'd5:    return r != 3'b100;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h0000_0000;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Runs one compare from IDLE and checks latency, busy/done exclusivity,
  // outputs at done and that they hold one cycle later.
  task automatic do_cmp(input string name, input logic [31:0] xa, input logic [31:0] xb,
                        input logic s, input logic [2:0] o);
    logic [2:0] er;
    logic       ec;
    int         lat;
    er  = ref_res(xa, xb, s);
    ec  = ref_cond(o, er);
    @(posedge clk); #1;
    start = 1'b1; a = xa; b = xb; is_signed = s; op = o;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom(); b = $urandom(); is_signed = $urandom_range(0, 1);
    op = 3'($urandom_range(0, 7));
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      checks++;
      if (busy === done) begin
        errors++;
        $display("FAIL %s busy_done busy=%b done=%b cycle=%0d", name, busy, done, lat);
      end
      if (done === 1'b1 || lat >= 10) break;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=3", name, lat);
    end
    checks++;
    if (result !== er || cond !== ec || slt_out !== {31'b0, er[0]}) begin
      errors++;
      $display("FAIL %s outputs got res=%b cond=%b slt=%h exp res=%b cond=%b slt=%h",
               name, result, cond, slt_out, er, ec, {31'b0, er[0]});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== er || cond !== ec) begin
      errors++;
      $display("FAIL %s hold got done=%b busy=%b res=%b cond=%b exp done=0 busy=0 res=%b cond=%b",
               name, done, busy, result, cond, er, ec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0; op = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 3'b010 || cond !== 1'b0 || slt_out !== 32'h0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b res=%b cond=%b slt=%h exp 0 0 010 0 0",
               busy, done, result, cond, slt_out);
    end
  endtask

  task automatic test_directed();
    do_cmp("signed_lt",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd2);
    do_cmp("unsigned_lt", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd2);
    do_cmp("lo_decides",  32'h1234_0005, 32'h1234_0009, 1'b0, 3'd5);
    do_cmp("eq_ne",       32'h8000_0000, 32'h8000_0000, 1'b1, 3'd1);
    do_cmp("eq_eq",       32'h8000_0000, 32'h8000_0000, 1'b1, 3'd0);
    do_cmp("ext_sgt",     32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'd4);
    do_cmp("ext_ugt",     32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'd4);
    do_cmp("zero_bgez",   32'h8000_0000, 32'h0000_0000, 1'b1, 3'd3);
    do_cmp("hi_decides",  32'h0001_FFFF, 32'h0002_0000, 1'b0, 3'd3);
    do_cmp("reserved",    32'h0000_0001, 32'h0000_0001, 1'b0, 3'd6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = pick_val();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick_val();
      if ($urandom_range(0, 3) == 0) rb = {ra[31:16], rb[15:0]};
      do_cmp($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_reset_mid();
    do_cmp("pre_abort", 32'h0000_0001, 32'h0000_0002, 1'b0, 3'd2);
    @(posedge clk); #1;
    start = 1'b1; a = 32'h0000_0003; b = 32'h0000_0009; is_signed = 1'b0; op = 3'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 3'b010 || cond !== 1'b0 || slt_out !== 32'h0) begin
      errors++;
      $display("FAIL abort got busy=%b done=%b res=%b cond=%b slt=%h exp 0 0 010 0 0",
               busy, done, result, cond, slt_out);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet got done=%b busy=%b exp 0 0", done, busy);
      end
    end
    do_cmp("post_abort", 32'h0000_0003, 32'h0000_0009, 1'b0, 3'd2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[10];
    logic [31:0] qb[10];
    logic        qs[10];
    logic [2:0]  qo[10];
    logic [2:0]  er;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      qa[c] = pick_val(); qb[c] = pick_val();
      qs[c] = 1'($urandom_range(0, 1)); qo[c] = 3'($urandom_range(0, 5));
      start = 1'b1; a = qa[c]; b = qb[c]; is_signed = qs[c]; op = qo[c];
      @(negedge clk);
      checks++;
      if (done !== (c == 3 || c == 7)) begin
        errors++;
        $display("FAIL b2b_done cycle=%0d got=%b exp=%b", c, done, (c == 3 || c == 7));
      end
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL b2b_busy_done cycle=%0d got busy=1 done=1 exp not both", c);
      end
      if (c == 3 || c == 7) begin
        er = ref_res(qa[c-3], qb[c-3], qs[c-3]);
        checks++;
        if (result !== er || cond !== ref_cond(qo[c-3], er) || slt_out !== {31'b0, er[0]}) begin
          errors++;
          $display("FAIL b2b_result cycle=%0d got res=%b cond=%b slt=%h exp res=%b cond=%b",
                   c, result, cond, slt_out, er, ref_cond(qo[c-3], er));
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
